// File: rtl/ecg_frame_packer.sv
// ecg_frame_packer: buffers 18-bit ECG samples in a FIFO and emits 5-byte framed packets on a byte stream
module ecg_frame_packer #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [17:0]                   ecg_sample,
    input  logic                          sample_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, SYNC, HDR, MID, LOW, CSUM} state_t;
    state_t state_q, state_d;
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] level_q, level_d;
    logic [15:0] ovf_q;
    logic [17:0] s_q;
    logic [5:0] seq_q;
    logic full, pop, push, drop, fire;
    logic [7:0] hdr, mid, low;
    assign full = level_q == (AW+1)'(FIFO_DEPTH);
    assign pop = state_q == IDLE && level_q != '0;
    // a pop frees the slot this cycle, so a write into a full FIFO is still accepted
    assign push = sample_valid && (!full || pop);
    assign drop = sample_valid && full && !pop;
    assign fire = tx_valid && tx_ready;
    assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    assign hdr = {seq_q, s_q[17:16]};
    assign mid = s_q[15:8];
    assign low = s_q[7:0];
    assign fifo_level = level_q;
    assign overflow_cnt = ovf_q;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ecg_sample;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
            ovf_q <= '0;
            s_q <= '0;
            seq_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q <= level_d;
            ovf_q <= (drop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
            s_q <= pop ? mem_q[rd_ptr_q] : s_q;
            seq_q <= (fire && state_q == CSUM) ? seq_q + 6'd1 : seq_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = pop ? SYNC : IDLE;
        else if (fire) state_d = state_q == CSUM ? IDLE : state_t'(state_q + 3'd1);
    end
    // outputs decode only registered state, so tx_ready never reaches tx_valid/tx_data
    always_comb begin
        tx_valid = state_q != IDLE;
        tx_data = state_q == SYNC ? SYNC_BYTE :
                  state_q == HDR  ? hdr :
                  state_q == MID  ? mid :
                  state_q == LOW  ? low :
                  state_q == CSUM ? 8'(hdr + mid + low) : 8'h00;
    end
endmodule

// File: tb/tb_ecg_frame_packer.sv
// tb_ecg_frame_packer: scoreboard bench for ecg_frame_packer; expected frame bytes are queued at stimulus time
module tb_ecg_frame_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [17:0] ecg_sample = '0;
    logic sample_valid = 1'b0;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready = 1'b0;
    logic [4:0] fifo_level;
    logic [15:0] overflow_cnt;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] q [$];
    logic [5:0] seq_m = '0;
    logic stall = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] exp_b;

    ecg_frame_packer dut (
        .clk(clk), .rst(rst), .ecg_sample(ecg_sample), .sample_valid(sample_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected frame for an accepted sample, numbered in acceptance order
    task automatic expect_frame(input logic [17:0] s);
        logic [7:0] h, m, l;
        h = {seq_m, s[17:16]};
        m = s[15:8];
        l = s[7:0];
        q.push_back(8'hA5);
        q.push_back(h);
        q.push_back(m);
        q.push_back(l);
        q.push_back(8'(h + m + l));
        seq_m = seq_m + 6'd1;
    endtask

    task automatic drive(input logic [17:0] s, input bit acc);
        @(posedge clk);
        #1 ecg_sample = s;
        sample_valid = 1'b1;
        if (acc) expect_frame(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 sample_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        #1 q.delete();
        seq_m = '0;
        repeat (2) @(posedge clk);
        #1 check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow_cnt, 0);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        tx_ready = 1'b1;
        while (n < 600 && !(q.size() == 0 && !tx_valid && fifo_level == 0)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sb_empty"}, q.size(), 0);
        check({tag, "_level"}, fifo_level, 0);
    endtask

    always @(negedge clk) begin
        if (rst) stall = 1'b0;
        else begin
            if (stall) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, held);
            end
            if (tx_valid && tx_ready) begin
                check("sb_has_byte", q.size() != 0, 1);
                if (q.size() != 0) begin
                    exp_b = q.pop_front();
                    check("byte", tx_data, exp_b);
                end
            end
            stall = tx_valid && !tx_ready;
            held = tx_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d bytes outstanding", q.size());
        $fatal(1);
    end

    initial begin
        int n;
        do_reset();
        // single sample, latency and first byte
        tx_ready = 1'b1;
        drive(18'h2ABCD, 1);
        idle(1);
        @(negedge clk);
        check("lat_valid_n1", tx_valid, 0);
        check("lat_level_n1", fifo_level, 1);
        @(negedge clk);
        check("lat_valid_n2", tx_valid, 1);
        check("lat_sync", tx_data, 8'hA5);
        check("lat_level_n2", fifo_level, 0);
        drain("t1");
        // stalled handshake with tx_ready toggling; seq now 1
        drive(18'h3FFFF, 1);
        idle(1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 tx_ready = ~tx_ready;
        end
        drain("t2");
        // seq field sweep and wrap
        do_reset();
        for (int i = 0; i < 65; i++) begin
            drive(18'($urandom), 1);
            idle(6);
        end
        drain("t3");
        // overflow with a stalled consumer
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) drive(18'(i * 4099 + 17), i < 17);
        idle(1);
        @(negedge clk);
        check("ovf_level", fifo_level, 16);
        check("ovf_cnt", overflow_cnt, 3);
        check("ovf_valid", tx_valid, 1);
        // release consumer, land a write on the IDLE pop while full
        tx_ready = 1'b1;
        n = 0;
        while (n < 20 && tx_valid) begin
            @(negedge clk);
            n++;
        end
        check("full_idle_seen", tx_valid, 0);
        ecg_sample = 18'h1C3A5;
        sample_valid = 1'b1;
        expect_frame(18'h1C3A5);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(negedge clk);
        check("full_pop_level", fifo_level, 16);
        check("full_pop_ovf", overflow_cnt, 3);
        drain("t5");
        // reset in the middle of a frame
        tx_ready = 1'b0;
        drive(18'h12345, 1);
        drive(18'h0F0F0, 1);
        drive(18'h2AAAA, 1);
        idle(1);
        n = 0;
        while (n < 20 && !tx_valid) begin
            @(negedge clk);
            n++;
        end
        check("mid_start", tx_valid, 1);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_ready = 1'b0;
        @(negedge clk);
        check("mid_byte", tx_data, 8'h23);
        rst = 1'b1;
        #1 check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        q.delete();
        seq_m = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        drive(18'h00ABC, 1);
        idle(1);
        drain("t6");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
